day2_range_loader: RTL and testbench
====================================

# day2_range_loader

Front-end controller for the day-2 invalid-ID engine. It parses the ASCII puzzle input (`start-end,start-end,...\n`) from a byte stream into binary ID ranges and packs up to NUM_UNITS ranges per batch into `day2_puzzle`'s `start_id`/`end_id` arrays. It sequences `load`/`en` for each batch, waits for `done`, and reports the final `id_sum` once the input is exhausted. It sits directly upstream of `day2_puzzle`.

## Interface
- W, 48, ID width in bits; must match `day2_puzzle` W.
- NUM_UNITS, 8, number of parallel `id_finder` units (ranges per batch).
- DONE_GUARD, 8, cycles after `load` during which `puzzle_done` is ignored (≥ 6, pipeline flush depth).

- clock  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  8  ASCII input byte.
- in_valid  in  1  `in_data` valid.
- in_ready  out  1  byte accepted when `in_valid & in_ready`.
- start_id  out  W × NUM_UNITS  unpacked array `[0:NUM_UNITS-1]` to `day2_puzzle.start_id`.
- end_id  out  W × NUM_UNITS  unpacked array `[0:NUM_UNITS-1]` to `day2_puzzle.end_id`.
- load  out  1  to `day2_puzzle.load`; 1-cycle pulse per batch.
- en  out  1  to `day2_puzzle.en`.
- puzzle_done  in  1  from `day2_puzzle.done`.
- puzzle_sum  in  W  from `day2_puzzle.id_sum`.
- result  out  W  final sum of invalid IDs.
- result_valid  out  1  sticky; high once `result` is final.
- error  out  1  sticky; high on a parse error or overflow.

## Operation
- States: S_START, S_END, LOAD, GUARD, WAIT, SETTLE, FINISH, ERR.
- `in_ready` = 1 only in S_START and S_END.
- Digits `'0'..'9'`:
  - Update `acc = acc*10 + d` at W bits.
  - Overflow past 2^W-1 → ERR.
  - Track `have_digit`.
- `' '` and `'\r'` are ignored in any parse state.
- `'-'` in S_START with `have_digit`: latch `acc` as start, clear `acc`/`have_digit`, go to S_END. Any other `'-'` → ERR.
- `','` in S_END with `have_digit`:
  - Commit (start, acc) to slot `idx`, then increment `idx`.
  - If `idx` reaches NUM_UNITS → LOAD, else → S_START.
  - `','` in S_START → ERR.
- `'\n'` or 0x04 (end of input):
  - Sets `last`.
  - In S_END with `have_digit`: commit the range first.
  - Then → LOAD if `idx > 0`, else → FINISH.
  - Seen in S_END without a digit → ERR.
- Any other byte → ERR.
- Empty slot value is start = 1, end = 0, so its unit is never in range and reports done immediately.
- LOAD: `load = 1`, `en = 0` for one cycle → GUARD.
- GUARD: `en = 1`; count DONE_GUARD cycles with `puzzle_done` ignored → WAIT.
- WAIT: `en = 1` until `puzzle_done = 1` → SETTLE.
- SETTLE: `en = 1` for 2 cycles to cover the gatherer's registered adder. Then:
  - If `last`: → FINISH.
  - Otherwise: reset all slots to empty, `idx = 0`, → S_START.
- FINISH:
  - `result <= puzzle_sum`, or 0 if no batch was ever loaded.
  - `result_valid = 1`, `in_ready = 0`; terminal until reset.
- `day2_puzzle` accumulators persist across batches, so the latest `puzzle_sum` is already the running total. This block adds nothing.
- ERR: `error = 1`, `in_ready = 0`, `en = 0`, `load = 0`; terminal until reset.

## Timing
- Reset values:
  - state S_START, `in_ready` 1.
  - `load` 0, `en` 0.
  - all slots empty (start 1, end 0), `idx` 0.
  - `result` 0, `result_valid` 0, `error` 0.
- Async assertion of `reset_n` forces these values immediately, including mid-batch. `load`/`en` drop without waiting for `done`.
- `start_id`/`end_id` are registered and stable from LOAD through SETTLE. A slot's registers change only on commit or on clear.
- LOAD is entered one cycle after the terminating byte is accepted; `load` is high for exactly 1 cycle.
- The first `en` cycle is the cycle after `load`.
- `puzzle_done` is sampled only in WAIT.
- `result_valid` rises 1 cycle after the last SETTLE cycle.
- Throughput: one byte per cycle while parsing.

## Test plan
- W=48, NUM_UNITS=8, PUZZLE=1, input "11-22,95-115\n" driven against a real `day2_puzzle` → exactly one `load` pulse; `result` = 132 with `result_valid` = 1.
- NUM_UNITS=2, input "1-9,10-20,30-40\n" → two `load` pulses, batch 2 slot 1 empty (1,0); `result` = 44.
- Input "12x" → `error` = 1 after the 'x' is accepted, `in_ready` = 0, `load` never pulses.
- W=8, input "300-" → overflow on the third digit, `error` = 1.
- Random `in_valid` gaps and `' '`/`'\r'` inserted into "11-22\n" → `result` = 33, no `error`.
- Input "\n" alone → `result` = 0, `result_valid` = 1, no `load`. Separately, `reset_n` pulsed low during WAIT → `en` = 0 asynchronously, state S_START, `in_ready` = 1, all outputs at reset values.

Source files
------------

// File: rtl/day2_range_loader.sv
// Parses "start-end,start-end,...\n" ASCII into ID ranges, batches them into
// day2_puzzle's slot arrays, sequences load/en per batch and reports the final sum.
module day2_range_loader #(
   parameter int W          = 48,
   parameter int NUM_UNITS  = 8,
   parameter int DONE_GUARD = 8
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] start_id [0:NUM_UNITS-1],
   output logic [W-1:0] end_id   [0:NUM_UNITS-1],
   output logic         load,
   output logic         en,
   input  logic         puzzle_done,
   input  logic [W-1:0] puzzle_sum,
   output logic [W-1:0] result,
   output logic         result_valid,
   output logic         error
);

   localparam int IDXW = $clog2(NUM_UNITS + 1);
   localparam int CNTW = $clog2(DONE_GUARD + 2);

   typedef enum logic [2:0] {
      S_START, S_END, LOAD, GUARD, WAIT, SETTLE, FINISH, ERR
   } state_t;

   state_t          state_reg;
   logic [W-1:0]    acc_reg;
   logic [W-1:0]    start_lat_reg;
   logic            have_digit_reg;
   logic            last_reg;
   logic            loaded_reg;
   logic [IDXW-1:0] idx_reg;
   logic [CNTW-1:0] cnt_reg;

   logic            accept;
   logic            is_digit, is_skip, is_dash, is_comma, is_eol;
   logic [W+3:0]    acc_wide;
   logic            acc_ovf;
   logic            commit;
   logic            clear_slots;
   logic [IDXW-1:0] idx_after;

   assign accept   = in_valid & in_ready;
   assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
   assign is_skip  = (in_data == 8'h20) || (in_data == 8'h0D);
   assign is_dash  = (in_data == 8'h2D);
   assign is_comma = (in_data == 8'h2C);
   assign is_eol   = (in_data == 8'h0A) || (in_data == 8'h04);

   // Four spare bits hold acc*10+9 for any W-bit acc, so overflow is just a nonzero top nibble.
   assign acc_wide = (W+4)'(acc_reg) * (W+4)'(10) + (W+4)'(in_data[3:0]);
   assign acc_ovf  = |acc_wide[W+3:W];

   assign commit      = accept && (state_reg == S_END) && have_digit_reg && (is_comma || is_eol);
   assign idx_after   = idx_reg + IDXW'(commit);
   assign clear_slots = (state_reg == SETTLE) && (cnt_reg == CNTW'(1)) && !last_reg;

   assign in_ready = (state_reg == S_START) || (state_reg == S_END);
   assign load     = (state_reg == LOAD);
   assign en       = (state_reg == GUARD) || (state_reg == WAIT) || (state_reg == SETTLE);
   assign error    = (state_reg == ERR);

   // Empty slot is (1,0): its id_finder sees an empty range and finishes at once.
   for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_slot
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            start_id[gi] <= W'(1);
            end_id[gi]   <= '0;
         end else if (clear_slots) begin
            start_id[gi] <= W'(1);
            end_id[gi]   <= '0;
         end else if (commit && (idx_reg == IDXW'(gi))) begin
            start_id[gi] <= start_lat_reg;
            end_id[gi]   <= acc_reg;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= S_START;
         acc_reg        <= '0;
         start_lat_reg  <= '0;
         have_digit_reg <= 1'b0;
         last_reg       <= 1'b0;
         loaded_reg     <= 1'b0;
         idx_reg        <= '0;
         cnt_reg        <= '0;
         result         <= '0;
         result_valid   <= 1'b0;
      end else begin
         case (state_reg)
            S_START, S_END: begin
               if (accept) begin
                  if (is_skip) begin
                     state_reg <= state_reg;
                  end else if (is_digit) begin
                     if (acc_ovf) begin
                        state_reg <= ERR;
                     end else begin
                        acc_reg        <= acc_wide[W-1:0];
                        have_digit_reg <= 1'b1;
                     end
                  end else if (is_dash) begin
                     if ((state_reg == S_START) && have_digit_reg) begin
                        start_lat_reg  <= acc_reg;
                        acc_reg        <= '0;
                        have_digit_reg <= 1'b0;
                        state_reg      <= S_END;
                     end else begin
                        state_reg <= ERR;
                     end
                  end else if (is_comma) begin
                     if (commit) begin
                        acc_reg        <= '0;
                        have_digit_reg <= 1'b0;
                        idx_reg        <= idx_after;
                        state_reg      <= (idx_after == IDXW'(NUM_UNITS)) ? LOAD : S_START;
                     end else begin
                        state_reg <= ERR;
                     end
                  end else if (is_eol) begin
                     if ((state_reg == S_END) && !have_digit_reg) begin
                        state_reg <= ERR;
                     end else begin
                        last_reg       <= 1'b1;
                        acc_reg        <= '0;
                        have_digit_reg <= 1'b0;
                        idx_reg        <= idx_after;
                        if (idx_after != '0) begin
                           state_reg <= LOAD;
                        end else begin
                           state_reg    <= FINISH;
                           result       <= loaded_reg ? puzzle_sum : '0;
                           result_valid <= 1'b1;
                        end
                     end
                  end else begin
                     state_reg <= ERR;
                  end
               end
            end
            LOAD: begin
               loaded_reg <= 1'b1;
               cnt_reg    <= '0;
               state_reg  <= GUARD;
            end
            // done from the previous batch may still be high while the pipeline flushes
            GUARD: begin
               if (cnt_reg == CNTW'(DONE_GUARD - 1)) begin
                  cnt_reg   <= '0;
                  state_reg <= WAIT;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            WAIT: begin
               if (puzzle_done) begin
                  cnt_reg   <= '0;
                  state_reg <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt_reg == CNTW'(1)) begin
                  cnt_reg <= '0;
                  if (last_reg) begin
                     state_reg    <= FINISH;
                     result       <= puzzle_sum;
                     result_valid <= 1'b1;
                  end else begin
                     idx_reg   <= '0;
                     state_reg <= S_START;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            FINISH:  state_reg <= FINISH;
            ERR:     state_reg <= ERR;
            default: state_reg <= ERR;
         endcase
      end
   end

endmodule

// File: tb/tb_day2_range_loader.sv
// Bench for day2_range_loader: two instances (W=48/8 units and W=8/2 units), each
// driving a behavioural day2_puzzle stand-in that sums repeated-half IDs.
module tb_day2_range_loader;

   localparam int WA = 48;
   localparam int NA = 8;
   localparam int WB = 8;
   localparam int NB = 2;
   localparam int DG = 8;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       sel_b = 1'b0;
   logic       hold_done = 1'b0;

   logic          in_valid_a, in_ready_a, load_a, en_a, done_a, rv_a, err_a;
   logic [WA-1:0] start_id_a [0:NA-1];
   logic [WA-1:0] end_id_a   [0:NA-1];
   logic [WA-1:0] sum_a, result_a;

   logic          in_valid_b, in_ready_b, load_b, en_b, done_b, rv_b, err_b;
   logic [WB-1:0] start_id_b [0:NB-1];
   logic [WB-1:0] end_id_b   [0:NB-1];
   logic [WB-1:0] sum_b, result_b;

   assign in_valid_a = in_valid & ~sel_b;
   assign in_valid_b = in_valid & sel_b;

   day2_range_loader #(.W(WA), .NUM_UNITS(NA), .DONE_GUARD(DG)) u_a (
      .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid_a),
      .in_ready(in_ready_a), .start_id(start_id_a), .end_id(end_id_a), .load(load_a),
      .en(en_a), .puzzle_done(done_a), .puzzle_sum(sum_a), .result(result_a),
      .result_valid(rv_a), .error(err_a));

   day2_range_loader #(.W(WB), .NUM_UNITS(NB), .DONE_GUARD(DG)) u_b (
      .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid_b),
      .in_ready(in_ready_b), .start_id(start_id_b), .end_id(end_id_b), .load(load_b),
      .en(en_b), .puzzle_done(done_b), .puzzle_sum(sum_b), .result(result_b),
      .result_valid(rv_b), .error(err_b));

   logic            cur_ready, cur_load, cur_en, cur_rv, cur_err;
   longint unsigned cur_result;
   assign cur_ready  = sel_b ? in_ready_b : in_ready_a;
   assign cur_load   = sel_b ? load_b : load_a;
   assign cur_en     = sel_b ? en_b : en_a;
   assign cur_rv     = sel_b ? rv_b : rv_a;
   assign cur_err    = sel_b ? err_b : err_a;
   assign cur_result = sel_b ? 64'(result_b) : 64'(result_a);

   function automatic bit is_inv(input longint unsigned n);
      longint unsigned t = n;
      longint unsigned p = 1;
      int d = 0;
      while (t > 0) begin
         t = t / 10;
         d++;
      end
      if (d == 0 || (d % 2) != 0) return 1'b0;
      for (int i = 0; i < d / 2; i++) p = p * 10;
      return (n / p) == (n % p);
   endfunction

   function automatic longint unsigned inv_sum(input longint unsigned s, input longint unsigned e);
      longint unsigned t = 0;
      for (longint unsigned n = s; n <= e; n++) if (is_inv(n)) t += n;
      return t;
   endfunction

   function automatic longint unsigned batch_a();
      longint unsigned t = 0;
      for (int i = 0; i < NA; i++) t += inv_sum(64'(start_id_a[i]), 64'(end_id_a[i]));
      return t;
   endfunction

   function automatic longint unsigned batch_b();
      longint unsigned t = 0;
      for (int i = 0; i < NB; i++) t += inv_sum(64'(start_id_b[i]), 64'(end_id_b[i]));
      return t;
   endfunction

   // Puzzle stand-ins: running sum across batches, done rises early (inside the guard window).
   logic [3:0] mcnt_a, mcnt_b;
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sum_a <= '0; done_a <= 1'b0; mcnt_a <= '0;
      end else if (load_a) begin
         sum_a <= sum_a + WA'(batch_a()); done_a <= 1'b0; mcnt_a <= '0;
      end else if (en_a) begin
         if (mcnt_a != 4'hF) mcnt_a <= mcnt_a + 1'b1;
         done_a <= (mcnt_a >= 4'd3) && !hold_done;
      end
   end

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sum_b <= '0; done_b <= 1'b0; mcnt_b <= '0;
      end else if (load_b) begin
         sum_b <= sum_b + WB'(batch_b()); done_b <= 1'b0; mcnt_b <= '0;
      end else if (en_b) begin
         if (mcnt_b != 4'hF) mcnt_b <= mcnt_b + 1'b1;
         done_b <= (mcnt_b >= 4'd3) && !hold_done;
      end
   end

   int pulses_a = 0, cycles_a = 0, pulses_b = 0, cycles_b = 0;
   logic prev_a = 1'b0, prev_b = 1'b0;
   logic [WB-1:0] cap_s_b [0:NB-1];
   logic [WB-1:0] cap_e_b [0:NB-1];
   always @(posedge clock) begin
      if (load_a) cycles_a <= cycles_a + 1;
      if (load_a && !prev_a) pulses_a <= pulses_a + 1;
      prev_a <= load_a;
      if (load_b) cycles_b <= cycles_b + 1;
      if (load_b && !prev_b) pulses_b <= pulses_b + 1;
      prev_b <= load_b;
      if (load_b) for (int i = 0; i < NB; i++) begin
         cap_s_b[i] <= start_id_b[i];
         cap_e_b[i] <= end_id_b[i];
      end
   end

   int n_applied = 0;
   int n_mis = 0;

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      n_applied++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      @(posedge clock);
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #2 reset_n = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps, output bit ok);
      int w = 0;
      ok = 1'b0;
      if (gaps) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
      end
      in_data  = b;
      in_valid = 1'b1;
      while (!cur_ready && !cur_err && w < 300) begin @(posedge clock); #1; w++; end
      if (cur_ready) begin
         @(posedge clock); #1;
         ok = 1'b1;
      end
      in_valid = 1'b0;
   endtask

   typedef struct {
      string           s;
      bit              on_b;
      bit              gaps;
      longint unsigned exp_result;
      bit              exp_err;
      int              exp_loads;
   } vec_t;

   typedef struct {
      longint unsigned result;
      bit              err;
      int              loads;
   } exp_t;

   exp_t sb[$];

   task automatic run_vec(input vec_t v, input int id);
      int   p0, c0, w;
      bit   ok;
      exp_t e;
      sel_b = v.on_b;
      do_reset();
      p0 = v.on_b ? pulses_b : pulses_a;
      c0 = v.on_b ? cycles_b : cycles_a;
      sb.push_back('{v.exp_result, v.exp_err, v.exp_loads});
      for (int i = 0; i < v.s.len(); i++) begin
         if (cur_err) break;
         send_byte(v.s[i], v.gaps, ok);
         if (!ok) break;
      end
      w = 0;
      while (!cur_rv && !cur_err && w < 500) begin @(posedge clock); #1; w++; end
      repeat (3) @(posedge clock);
      #1;
      e = sb.pop_front();
      $display("vector %0d on %s: result=%0d valid=%0d error=%0d loads=%0d", id,
               v.on_b ? "B" : "A", cur_result, cur_rv, cur_err,
               (v.on_b ? pulses_b : pulses_a) - p0);
      chk($sformatf("v%0d.error", id), 64'(cur_err), 64'(e.err));
      chk($sformatf("v%0d.result_valid", id), 64'(cur_rv), 64'(!e.err));
      chk($sformatf("v%0d.result", id), cur_result, e.result);
      chk($sformatf("v%0d.load_pulses", id), 64'((v.on_b ? pulses_b : pulses_a) - p0), 64'(e.loads));
      chk($sformatf("v%0d.load_cycles", id), 64'((v.on_b ? cycles_b : cycles_a) - c0), 64'(e.loads));
      chk($sformatf("v%0d.in_ready", id), 64'(cur_ready), 64'(0));
      chk($sformatf("v%0d.en", id), 64'(cur_en), 64'(0));
      chk($sformatf("v%0d.load", id), 64'(cur_load), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt [12];
      string s;
      int    w;
      bit    ok;

      vt[0]  = '{"11-22,95-115\n", 1'b0, 1'b0, 132, 1'b0, 1};
      vt[1]  = '{"1-9,10-20,30-40\n", 1'b1, 1'b0, 44, 1'b0, 2};
      vt[2]  = '{"12x", 1'b0, 1'b0, 0, 1'b1, 0};
      vt[3]  = '{"300-", 1'b1, 1'b0, 0, 1'b1, 0};
      vt[4]  = '{"1 1\015-22\015\n", 1'b0, 1'b1, 33, 1'b0, 1};
      vt[5]  = '{"\n", 1'b0, 1'b0, 0, 1'b0, 0};
      vt[6]  = '{"11-22,95-115\004", 1'b0, 1'b0, 132, 1'b0, 1};
      vt[7]  = '{"5-3,-", 1'b0, 1'b0, 0, 1'b1, 0};
      vt[8]  = '{"1-\n", 1'b0, 1'b0, 0, 1'b1, 0};
      vt[9]  = '{"1-2-", 1'b0, 1'b0, 0, 1'b1, 0};
      vt[10] = '{"11-22,33-44,\n", 1'b1, 1'b0, 110, 1'b0, 1};
      vt[11] = '{"1-1,2-2,3-3,4-4,5-5,6-6,7-7,8-8,11-11\n", 1'b0, 1'b0, 11, 1'b0, 2};

      // Reset state of both instances.
      sel_b = 1'b0;
      do_reset();
      chk("reset.in_ready", 64'(in_ready_a), 1);
      chk("reset.load", 64'(load_a), 0);
      chk("reset.en", 64'(en_a), 0);
      chk("reset.result", 64'(result_a), 0);
      chk("reset.result_valid", 64'(rv_a), 0);
      chk("reset.error", 64'(err_a), 0);
      for (int i = 0; i < NA; i++) begin
         chk($sformatf("reset.a_start%0d", i), 64'(start_id_a[i]), 1);
         chk($sformatf("reset.a_end%0d", i), 64'(end_id_a[i]), 0);
      end
      for (int i = 0; i < NB; i++) begin
         chk($sformatf("reset.b_start%0d", i), 64'(start_id_b[i]), 1);
         chk($sformatf("reset.b_end%0d", i), 64'(end_id_b[i]), 0);
      end

      for (int i = 0; i < 12; i++) run_vec(vt[i], i);

      // Second batch on the 2-unit instance leaves slot 1 empty.
      run_vec(vt[1], 12);
      chk("batch2.slot0_start", 64'(cap_s_b[0]), 30);
      chk("batch2.slot0_end", 64'(cap_e_b[0]), 40);
      chk("batch2.slot1_start", 64'(cap_s_b[1]), 1);
      chk("batch2.slot1_end", 64'(cap_e_b[1]), 0);

      // load/en timing, then asynchronous reset while waiting for done.
      sel_b = 1'b0;
      do_reset();
      hold_done = 1'b1;
      s = "11-22\n";
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0, ok);
      w = 0;
      while (!load_a && w < 50) begin @(posedge clock); #1; w++; end
      chk("wait.load_seen", 64'(load_a), 1);
      chk("wait.en_during_load", 64'(en_a), 0);
      @(posedge clock); #1;
      chk("wait.load_one_cycle", 64'(load_a), 0);
      chk("wait.first_en", 64'(en_a), 1);
      repeat (DG + 3) @(posedge clock);
      #1;
      chk("wait.en_in_wait", 64'(en_a), 1);
      chk("wait.no_result", 64'(rv_a), 0);
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      $display("async reset during WAIT: en=%0d in_ready=%0d load=%0d", en_a, in_ready_a, load_a);
      chk("areset.en", 64'(en_a), 0);
      chk("areset.load", 64'(load_a), 0);
      chk("areset.in_ready", 64'(in_ready_a), 1);
      chk("areset.result", 64'(result_a), 0);
      chk("areset.result_valid", 64'(rv_a), 0);
      chk("areset.error", 64'(err_a), 0);
      chk("areset.slot0_start", 64'(start_id_a[0]), 1);
      chk("areset.slot0_end", 64'(end_id_a[0]), 0);
      hold_done = 1'b0;
      @(posedge clock);
      #2 reset_n = 1'b1;
      @(posedge clock);
      #1;
      chk("areset.ready_after", 64'(in_ready_a), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_mis);
      $finish;
   end

endmodule
